// File: rtl/hvtx_motion_ctl.sv
// Moving-box origin controller: steps a BOX_SIZE square once every FRAMES_PER_STEP vblanks.
// Define HVTX_MOTION_BOUNCE_EN for bounce motion; the default build walks the box in raster order.
module hvtx_motion_ctl #(
    parameter int WIDTH           = 11,
    parameter int ACTIVE_WIDTH    = 1280,
    parameter int ACTIVE_HEIGHT   = 720,
    parameter int BOX_SIZE        = 10,
    parameter int STEP            = 10,
    parameter int FRAMES_PER_STEP = 1,
    localparam int FCW            = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_vblank,
    input  logic             i_pause,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_x,
    input  logic [WIDTH-1:0] i_load_y,
    input  logic [WIDTH-1:0] i_x,
    input  logic [WIDTH-1:0] i_y,
    output logic [WIDTH-1:0] o_box_x,
    output logic [WIDTH-1:0] o_box_y,
    output logic             o_hit,
    output logic             o_update,
    output logic [1:0]       o_dbg_state,
    output logic [FCW-1:0]   o_dbg_frm_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_STEP  = 2'd2,
        S_PAUSE = 2'd3
    } state_t;

    localparam logic [WIDTH:0]   XMAX     = (WIDTH+1)'(ACTIVE_WIDTH - BOX_SIZE);
    localparam logic [WIDTH:0]   YMAX     = (WIDTH+1)'(ACTIVE_HEIGHT - BOX_SIZE);
    localparam logic [WIDTH-1:0] XMAX_N   = WIDTH'(ACTIVE_WIDTH - BOX_SIZE);
    localparam logic [WIDTH-1:0] YMAX_N   = WIDTH'(ACTIVE_HEIGHT - BOX_SIZE);
    localparam logic [WIDTH:0]   STEP_W   = (WIDTH+1)'(STEP);
    localparam logic [WIDTH:0]   BOX_W    = (WIDTH+1)'(BOX_SIZE);
    localparam logic [FCW-1:0]   FRM_LAST = FCW'(FRAMES_PER_STEP - 1);

    state_t           state_q, state_d;
    logic [FCW-1:0]   frm_cnt_q, frm_cnt_d;
    logic [WIDTH-1:0] box_x_q, box_x_d;
    logic [WIDTH-1:0] box_y_q, box_y_d;
    logic             hit_q, hit_d;
    logic             update_q, update_d;
    logic             dx_q, dx_d;   // 1 = moving toward 0
    logic             dy_q, dy_d;

    // Step arithmetic is carried one bit wider than the coordinates.
    logic [WIDTH:0]   bx, by, sum_x, sum_y, nx, ny;
    logic             ndx, ndy;

    always_comb begin
        bx    = {1'b0, box_x_q};
        by    = {1'b0, box_y_q};
        sum_x = bx + STEP_W;
        sum_y = by + STEP_W;
        nx    = bx;
        ny    = by;
        ndx   = dx_q;
        ndy   = dy_q;
`ifdef HVTX_MOTION_BOUNCE_EN
        if (!dx_q) begin
            if (sum_x >= XMAX) begin
                nx  = XMAX;
                ndx = 1'b1;
            end else begin
                nx = sum_x;
            end
        end else begin
            if (bx <= STEP_W) begin
                nx  = '0;
                ndx = 1'b0;
            end else begin
                nx = bx - STEP_W;
            end
        end
        if (!dy_q) begin
            if (sum_y >= YMAX) begin
                ny  = YMAX;
                ndy = 1'b1;
            end else begin
                ny = sum_y;
            end
        end else begin
            if (by <= STEP_W) begin
                ny  = '0;
                ndy = 1'b0;
            end else begin
                ny = by - STEP_W;
            end
        end
`else
        if (sum_x > XMAX) begin
            nx = '0;
            ny = (sum_y > YMAX) ? '0 : sum_y;
        end else begin
            nx = sum_x;
        end
`endif
    end

    always_comb begin
        state_d   = state_q;
        frm_cnt_d = frm_cnt_q;
        box_x_d   = box_x_q;
        box_y_d   = box_y_q;
        update_d  = 1'b0;
        dx_d      = dx_q;
        dy_d      = dy_q;

        unique case (state_q)
            S_IDLE: begin
                if (i_vblank) state_d = S_RUN;
            end
            S_RUN: begin
                if (i_vblank) begin
                    if (frm_cnt_q == FRM_LAST) begin
                        frm_cnt_d = '0;
                        state_d   = S_STEP;
                    end else begin
                        frm_cnt_d = frm_cnt_q + 1'b1;
                        if (i_pause) state_d = S_PAUSE;
                    end
                end else if (i_pause) begin
                    state_d = S_PAUSE;
                end
            end
            S_STEP: begin
                box_x_d  = nx[WIDTH-1:0];
                box_y_d  = ny[WIDTH-1:0];
                dx_d     = ndx;
                dy_d     = ndy;
                update_d = 1'b1;
                state_d  = i_pause ? S_PAUSE : S_RUN;
            end
            S_PAUSE: begin
                if (!i_pause) state_d = S_RUN;
            end
            default: state_d = S_IDLE;
        endcase

        // A load overrides any step computed above but never starts the FSM.
        if (i_load) begin
            box_x_d   = ({1'b0, i_load_x} > XMAX) ? XMAX_N : i_load_x;
            box_y_d   = ({1'b0, i_load_y} > YMAX) ? YMAX_N : i_load_y;
            frm_cnt_d = '0;
            update_d  = 1'b0;
            dx_d      = dx_q;
            dy_d      = dy_q;
            if (state_q == S_IDLE) state_d = S_IDLE;
        end
    end

    always_comb begin
        hit_d = ({1'b0, i_x} >= bx) && ({1'b0, i_x} < bx + BOX_W) &&
                ({1'b0, i_y} >= by) && ({1'b0, i_y} < by + BOX_W);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= S_IDLE;
            frm_cnt_q <= '0;
            box_x_q   <= '0;
            box_y_q   <= '0;
            hit_q     <= 1'b0;
            update_q  <= 1'b0;
            dx_q      <= 1'b0;
            dy_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            frm_cnt_q <= frm_cnt_d;
            box_x_q   <= box_x_d;
            box_y_q   <= box_y_d;
            hit_q     <= hit_d;
            update_q  <= update_d;
            dx_q      <= dx_d;
            dy_q      <= dy_d;
        end
    end

    assign o_box_x       = box_x_q;
    assign o_box_y       = box_y_q;
    assign o_hit         = hit_q;
    assign o_update      = update_q;
    assign o_dbg_state   = state_q;
    assign o_dbg_frm_cnt = frm_cnt_q;

endmodule
